// File: rtl/bht_update_scheduler.sv
// rtl/bht_update_scheduler.sv - 2-bit counter BHT with single access slot shared by fetch lookups and queued outcome updates
module bht_update_scheduler #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear_table,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            lookup_ready,
  output logic            predict_valid,
  output logic            predict_taken,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  output logic            update_ready,
  output logic            init_busy
);

  localparam int               ENTRIES  = 1 << INDEX_BITS;
  localparam int               PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]      CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [0:0]       ST_INIT  = 1'b0;
  localparam logic [0:0]       ST_RUN   = 1'b1;

  logic [0:0]            r_state;
  logic [INDEX_BITS-1:0] r_init_idx;
  logic [1:0]            r_table [ENTRIES];
  logic [INDEX_BITS-1:0] r_fifo_idx [FIFO_DEPTH];
  logic                  r_fifo_taken [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW:0]           r_count;
  logic                  r_predict_valid;
  logic                  r_predict_taken;

  logic                  w_run;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_lookup_fire;
  logic                  w_enq;
  logic                  w_deq;
  logic [INDEX_BITS-1:0] w_lookup_idx;
  logic [INDEX_BITS-1:0] w_update_idx;
  logic [INDEX_BITS-1:0] w_head_idx;
  logic                  w_head_taken;
  logic [1:0]            w_head_ctr;
  logic [1:0]            w_head_next;
  logic                  w_tbl_we;
  logic [INDEX_BITS-1:0] w_tbl_widx;
  logic [1:0]            w_tbl_wdata;
  logic                  w_unused_pc_bits;

  assign w_lookup_idx     = lookup_pc[INDEX_BITS+1:2];
  assign w_update_idx     = update_pc[INDEX_BITS+1:2];
  assign w_unused_pc_bits = ^{lookup_pc[XLEN-1:INDEX_BITS+2], lookup_pc[1:0],
                              update_pc[XLEN-1:INDEX_BITS+2], update_pc[1:0]};

  assign w_run   = (r_state == ST_RUN);
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // A full queue takes the slot from fetch so that updates can never starve.
  assign lookup_ready  = w_run && !w_full && !clear_table;
  assign update_ready  = w_run && !w_full && !clear_table;
  assign w_lookup_fire = lookup_valid && lookup_ready;
  assign w_enq         = update_valid && update_ready;
  assign w_deq         = w_run && !clear_table && !w_empty && (w_full || !lookup_valid);

  assign w_head_idx   = r_fifo_idx[r_rd_ptr];
  assign w_head_taken = r_fifo_taken[r_rd_ptr];
  assign w_head_ctr   = r_table[w_head_idx];

  always_comb begin
    w_head_next = w_head_ctr;
    if (w_head_taken) begin
      if (w_head_ctr != 2'b11) w_head_next = w_head_ctr + 2'b01;
    end else begin
      if (w_head_ctr != 2'b00) w_head_next = w_head_ctr - 2'b01;
    end
  end

  always_comb begin
    w_tbl_we    = 1'b0;
    w_tbl_widx  = w_head_idx;
    w_tbl_wdata = w_head_next;
    if (!w_run && !clear_table) begin
      w_tbl_we    = 1'b1;
      w_tbl_widx  = r_init_idx;
      w_tbl_wdata = 2'b01;
    end else if (w_deq) begin
      w_tbl_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tbl_we) r_table[w_tbl_widx] <= w_tbl_wdata;
    if (w_enq) begin
      r_fifo_idx[r_wr_ptr]   <= w_update_idx;
      r_fifo_taken[r_wr_ptr] <= update_taken;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else if (clear_table) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else if (!w_run) begin
      r_init_idx <= r_init_idx + 1'b1;
      if (r_init_idx == INDEX_BITS'(ENTRIES - 1)) r_state <= ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_table) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_predict_valid <= 1'b0;
      r_predict_taken <= 1'b0;
    end else begin
      r_predict_valid <= w_lookup_fire;
      r_predict_taken <= w_lookup_fire ? r_table[w_lookup_idx][1] : 1'b0;
    end
  end

  assign predict_valid = r_predict_valid;
  assign predict_taken = r_predict_taken;
  assign init_busy     = !w_run;

endmodule

// File: tb/tb_bht_update_scheduler.sv
// tb/tb_bht_update_scheduler.sv - directed self-checking bench for bht_update_scheduler
module tb_bht_update_scheduler;

  logic        clk;
  logic        reset_n;
  logic        clear_table;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        lookup_ready;
  logic        predict_valid;
  logic        predict_taken;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_ready;
  logic        init_busy;

  int n_tests = 0;
  int n_fail  = 0;

  bht_update_scheduler #(.XLEN(32), .INDEX_BITS(6), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear_table   (clear_table),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .lookup_ready  (lookup_ready),
    .predict_valid (predict_valid),
    .predict_taken (predict_taken),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_ready  (update_ready),
    .init_busy     (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Tasks below start and end just after a falling edge.
  task automatic wait_init(output int cnt, output bit rdy_seen);
    cnt = 0;
    rdy_seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (!init_busy) break;
      cnt++;
      if (lookup_ready || update_ready) rdy_seen = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enq(input logic [31:0] pc, input logic t);
    update_valid = 1'b1;
    update_pc    = pc;
    update_taken = t;
    @(negedge clk);
    update_valid = 1'b0;
  endtask

  task automatic lookup_get(input logic [31:0] pc, output logic v, output logic t);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    @(negedge clk);
    lookup_valid = 1'b0;
    v = predict_valid;
    t = predict_taken;
  endtask

  task automatic do_lookup(input logic [31:0] pc, input logic exp, input string tag);
    logic v, t;
    lookup_get(pc, v, t);
    check(tag, {30'd0, v, t}, {30'd0, 1'b1, exp});
  endtask

  initial begin
    int  cnt;
    bit  rdy_seen;
    int  bad;
    logic v, t;

    reset_n      = 1'b0;
    clear_table  = 1'b0;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h100;
    update_valid = 1'b0;
    update_pc    = '0;
    update_taken = 1'b0;

    // 1: reset values and init sweep length
    repeat (3) @(negedge clk);
    check("rst_outs", {28'd0, init_busy, lookup_ready, update_ready, predict_valid}, 32'h8);
    check("rst_ptaken", {31'd0, predict_taken}, 32'h0);
    reset_n = 1'b1;
    wait_init(cnt, rdy_seen);
    lookup_valid = 1'b0;
    check("init_cycles", cnt, 64);
    check("init_rdy_low", {31'd0, rdy_seen}, 32'h0);
    check("run_pv_idle", {31'd0, predict_valid}, 32'h0);
    do_lookup(32'h0000_0100, 1'b0, "t1_first_lookup");

    // 2: saturation at index 16
    enq(32'h40, 1'b1); enq(32'h40, 1'b1); enq(32'h40, 1'b1);
    idle(6);
    do_lookup(32'h40, 1'b1, "t2_sat3");
    enq(32'h40, 1'b1);
    idle(4);
    do_lookup(32'h40, 1'b1, "t2_still3");
    enq(32'h40, 1'b0);
    idle(4);
    do_lookup(32'h40, 1'b1, "t2_dec_to2");
    enq(32'h40, 1'b0);
    idle(4);
    do_lookup(32'h40, 1'b0, "t2_dec_to1");

    // 3: held lookup blocks dequeue until the queue fills
    lookup_valid = 1'b1;
    lookup_pc    = 32'h200;
    for (int k = 0; k < 4; k++) begin
      update_valid = 1'b1;
      update_pc    = 32'h80;
      update_taken = 1'b1;
      #1 check($sformatf("t3_rdy_%0d", k), {30'd0, lookup_ready, update_ready}, 32'h3);
      @(negedge clk);
    end
    update_valid = 1'b0;
    #1 check("t3_full_rdy", {30'd0, lookup_ready, update_ready}, 32'h0);
    check("t3_pred_held", {30'd0, predict_valid, predict_taken}, 32'h2);
    @(negedge clk);
    #1 check("t3_after_drain", {29'd0, lookup_ready, update_ready, predict_valid}, 32'h6);
    lookup_valid = 1'b0;
    idle(6);
    do_lookup(32'h80, 1'b1, "t3_ctr");

    // 4: enqueue+dequeue at count 3, order T,T,T,N,N on index 48
    lookup_valid = 1'b1;
    lookup_pc    = 32'h200;
    for (int k = 0; k < 3; k++) enq(32'hC0, 1'b1);
    lookup_valid = 1'b0;
    update_valid = 1'b1;
    update_pc    = 32'hC0;
    update_taken = 1'b0;
    @(negedge clk);
    lookup_valid = 1'b1;
    #1 check("t4_cnt3", {30'd0, lookup_ready, update_ready}, 32'h3);
    @(negedge clk);
    update_valid = 1'b0;
    #1 check("t4_full", {31'd0, lookup_ready}, 32'h0);
    lookup_valid = 1'b0;
    idle(6);
    do_lookup(32'hC0, 1'b0, "t4_order");
    enq(32'hC0, 1'b1);
    idle(3);
    do_lookup(32'hC0, 1'b1, "t4_applied");

    // 5: aliasing across bit 8
    enq(32'h10, 1'b1); enq(32'h10, 1'b1);
    idle(4);
    do_lookup(32'h0000_0110, 1'b1, "t5_alias");

    // 6: clear with three queued taken updates to index 8
    lookup_valid = 1'b1;
    lookup_pc    = 32'h200;
    for (int k = 0; k < 3; k++) enq(32'h20, 1'b1);
    clear_table = 1'b1;
    #1 check("t6_clr_rdy", {30'd0, lookup_ready, update_ready}, 32'h0);
    check("t6_pv_before", {31'd0, predict_valid}, 32'h1);
    @(negedge clk);
    clear_table  = 1'b0;
    lookup_valid = 1'b0;
    #1 check("t6_state", {29'd0, predict_valid, init_busy, update_ready}, 32'h2);
    wait_init(cnt, rdy_seen);
    check("t6_init_cycles", cnt, 64);
    idle(6);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      lookup_get(32'(i) << 2, v, t);
      if (!(v === 1'b1 && t === 1'b0)) bad++;
    end
    check("t6_sweep_bad", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
